dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory (dm).
- Shares dm between port 0 (CPU load/store) and port 1 (DMA/test loader).
- Serialises one transaction at a time and generates the dm write-enable pulse with address/data setup and hold. dm writes on the rising edge of dm_we; reads are combinational.
- Sits between the CPU/loader and dm; dm itself is unchanged.

Parameters:
AW, 16, address width (dm word address)
DW, 32, data word width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset: synchronous, active-high
p0_req  in  1  port 0 request; held high until p0_ack
p0_we  in  1  port 0 direction: 1 = write, 0 = read
p0_addr  in  AW  port 0 word address
p0_wdata  in  DW  port 0 write data
p0_ack  out  1  port 0 completion, one-cycle pulse
p0_rdata  out  DW  port 0 read data, valid when p0_ack=1, held until next port 0 read
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
dm_read_addr  out  AW  to dm read_addr
dm_write_addr  out  AW  to dm write_addr
dm_write_data  out  DW  to dm write_data
dm_we  out  1  to dm dm_we; registered, glitch-free
dm_read_data  in  DW  from dm read_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: at any rising edge with rst=1, all of the following are cleared:
  - state = IDLE
  - all outputs = 0 (acks, rdata, dm addresses/data, dm_we)
  - last_grant = 1, so port 0 wins the first tie
- Reset overrides every other event.
- Reset mid-transaction: no ack is issued. If dm_we had already risen, the write is committed in dm. dm_we is 0 in the cycle after the reset edge.
- States: IDLE, RD, WR_SETUP, WR_PULSE.
- IDLE:
  - Eligible ports are those with pN_req=1 and pN_ack=0. A req still high during its own ack cycle is ignored, which prevents duplicate transactions.
  - If no port is eligible, stay in IDLE.
  - If one port is eligible, grant it.
  - If both are eligible, grant the port != last_grant.
  - On grant:
    - update last_grant
    - latch the granted port's we/addr/wdata
    - read: dm_read_addr <= addr, next state RD
    - write: dm_write_addr <= addr, dm_write_data <= wdata, next state WR_SETUP
- RD (1 cycle): dm settles. At the edge, the granted pN_rdata <= dm_read_data, pN_ack <= 1, next state IDLE.
- WR_SETUP (1 cycle): address/data stable, dm_we=0. At the edge, dm_we <= 1, next state WR_PULSE.
- WR_PULSE (1 cycle): dm_we=1 and dm commits the write. At the edge, dm_we <= 0, pN_ack <= 1, next state IDLE.
- Address/data hold: dm_write_addr and dm_write_data hold their values until the next write grant, giving hold past dm_we fall. dm_read_addr holds until the next read grant.
- Ack: a registered pulse lasting exactly one cycle, cleared at the next edge. At most one ack is high per cycle. The non-granted port's rdata never changes.
- Latency, counted from the edge where IDLE samples req:
  - read: ack high 2 cycles later (edge +2)
  - write: ack high 3 cycles later (edge +3)
- Throughput: the same port can be granted again at the earliest 1 cycle after its ack (IDLE cycle). With both ports requesting continuously, grants strictly alternate.
- Read-after-write to the same address always returns the new data, because transactions are serialised.
- Inputs change only in the requester's own clock domain (clk). There is no width conversion; addresses pass through unchanged.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both reqs high -> all outputs 0, busy=0, no ack; after rst falls, port 0 is granted first.
- p0 write addr 0x0010 data 0xDEADBEEF:
  - dm_write_addr=0x0010 and dm_write_data=0xDEADBEEF in the WR_SETUP cycle with dm_we=0
  - dm_we=1 for exactly one cycle
  - p0_ack pulses at edge +3
  - then p0 read 0x0010 -> p0_rdata=0xDEADBEEF with p0_ack at edge +2
- Both ports request continuously (p0 read 0x0001, p1 read 0x0002) -> grant order p0,p1,p0,p1; acks never overlap; each rdata matches its own address.
- p0 holds req high through its ack cycle and drops it after -> exactly one transaction; dm_we pulses once for a write; busy falls.
- Assert rst during WR_PULSE of a p1 write to 0x0020 with data 0x12345678:
  - no p1_ack; dm_we=0 next cycle
  - a subsequent p1 read of 0x0020 returns 0x12345678 (write committed)
- p1 read of 0x0005 while p0 is idle -> only p1_ack pulses; p0_rdata is unchanged from its previous value.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the data memory (dm).
//
// Port 0 (CPU load/store) and port 1 (DMA / test loader) share one dm.
// One transaction is in flight at a time. Reads take one settle cycle.
// Writes get one setup cycle and one dm_we pulse cycle. Address and data
// stay on the dm bus after dm_we falls, which gives hold time.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   pN_req/we/addr/wdata  port N request, held until pN_ack
//   pN_ack                one-cycle completion pulse
//   pN_rdata              read data, valid with pN_ack, held until next read
//   dm_read_addr          dm read address (dm read is combinational)
//   dm_write_addr/data    dm write address/data, held until next write grant
//   dm_we                 registered dm write strobe (dm writes on its rise)
//   dm_read_data          dm combinational read data
//   busy                  high while a transaction is in progress

// Per-port completion logic: ack pulse and read-data holding register.
module dm_arb_port #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic          load,
  input  logic [DW-1:0] dm_read_data,
  output logic          ack,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= done;
      if (load) rdata <= dm_read_data;
    end
  end
endmodule

module dm_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] dm_read_addr,
  output logic [AW-1:0] dm_write_addr,
  output logic [DW-1:0] dm_write_data,
  output logic          dm_we,
  input  logic [DW-1:0] dm_read_data,
  output logic          busy
);
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, RD, WR_SETUP, WR_PULSE} state_t;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t [NP-1:0]          preq;
  logic [NP-1:0]          ack, done, load, elig;
  logic [NP-1:0][DW-1:0]  rdata;
  state_t                 state, state_nx;
  logic                   last_grant, gnt, pick, grant_en;

  assign preq[0] = '{req: p0_req, we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign preq[1] = '{req: p1_req, we: p1_we, addr: p1_addr, wdata: p1_wdata};

  // A request still high during its own ack cycle is the tail of the
  // transaction just finished, not a new one.
  assign elig = {preq[1].req & ~ack[1], preq[0].req & ~ack[0]};

  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    pick     = 1'b0;
    done     = '0;
    load     = '0;
    case (state)
      IDLE: begin
        if (|elig) begin
          grant_en = 1'b1;
          // On a tie the port that did not win last time goes next.
          pick     = (&elig) ? ~last_grant : elig[1];
          state_nx = preq[pick].we ? WR_SETUP : RD;
        end
      end
      RD: begin
        done[gnt] = 1'b1;
        load[gnt] = 1'b1;
        state_nx  = IDLE;
      end
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: begin
        done[gnt] = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      gnt           <= 1'b0;
      dm_read_addr  <= '0;
      dm_write_addr <= '0;
      dm_write_data <= '0;
      dm_we         <= 1'b0;
    end else begin
      state <= state_nx;
      // Strobe is a flop output, high only for the WR_PULSE cycle.
      dm_we <= (state == WR_SETUP);
      if (grant_en) begin
        last_grant <= pick;
        gnt        <= pick;
        if (preq[pick].we) begin
          dm_write_addr <= preq[pick].addr;
          dm_write_data <= preq[pick].wdata;
        end else begin
          dm_read_addr  <= preq[pick].addr;
        end
      end
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_port
    dm_arb_port #(.DW(DW)) u_port (
      .clk          (clk),
      .rst          (rst),
      .done         (done[i]),
      .load         (load[i]),
      .dm_read_data (dm_read_data),
      .ack          (ack[i]),
      .rdata        (rdata[i])
    );
  end

  assign p0_ack   = ack[0];
  assign p1_ack   = ack[1];
  assign p0_rdata = rdata[0];
  assign p1_rdata = rdata[1];
  assign busy     = (state != IDLE);

endmodule
